comparator_bist: RTL and testbench
==================================

// Module: comparator_bist
// PURPOSE
//   Hardware self-test sequencer for a magnitude comparator with flags F1 (A>B), F2 (A==B) and F3 (A<B).
//   - Drives every {A,B} operand pair into the comparator.
//   - Waits a programmable settle time per pair, samples F1/F2/F3 and checks them against the expected result.
//   - Counts mismatches and reports pass/fail.
//   - Sits beside the comparator at chip level; the comparator is the reader, this block is the writer/checker.
// PARAMETERS
//   WIDTH   1  operand width of A and B; vectors swept = 2**(2*WIDTH)
//   SETTLE  2  cycles each vector is held before sampling; legal range >= 1
//   CNT_W   8  width of ERR_CNT; the counter saturates at 2**CNT_W-1
// PORTS
//   CLK      in   1      rising-edge clock
//   RST_N    in   1      asynchronous active-low reset
//   START    in   1      begin a sweep; sampled in IDLE or DONE state only
//   A        out  WIDTH  operand A driven to the comparator
//   B        out  WIDTH  operand B driven to the comparator
//   F1       in   1      comparator flag, A>B
//   F2       in   1      comparator flag, A==B
//   F3       in   1      comparator flag, A<B
//   BUSY     out  1      high while a sweep is in progress
//   DONE     out  1      high from sweep end until the next START or reset
//   PASS     out  1      equals DONE && (ERR_CNT==0)
//   ERR_CNT  out  CNT_W  number of mismatching vectors in the last sweep
// BEHAVIOUR
//   Reset (RST_N low, asynchronous): state=IDLE; A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0.
//   States:
//   - IDLE: on START, go to SETTLE with vector {A,B}=0, ERR_CNT cleared, wait counter loaded with SETTLE-1.
//   - SETTLE: A/B held stable; counter decrements each cycle; at counter==0, go to CHECK.
//   - CHECK: one cycle; F1/F2/F3 sampled at the edge ending CHECK and compared with the expected
//     {A>B, A==B, A<B} computed from the driven A/B.
//       - Any bit differing is one error; non-one-hot flags are therefore errors.
//       - On error, ERR_CNT increments; it saturates at all-ones and never wraps.
//       - If {A,B} is the last vector (all ones), go to DONE; otherwise increment {A,B}, reload
//         the counter and return to SETTLE.
//   - DONE: DONE=1, BUSY=0, A/B hold the last vector; START restarts exactly as from IDLE (clears
//     DONE and ERR_CNT the same edge).
//   Vector order: {A,B} is one 2*WIDTH-bit up-counter with A as MSBs (W=1: 00,01,10,11).
//   Timing:
//   - BUSY=1 in SETTLE and CHECK; each vector occupies SETTLE+1 cycles.
//   - DONE rises exactly 2**(2*WIDTH)*(SETTLE+1) cycles after the START sampling edge.
//   START while BUSY is ignored; START held high in DONE retriggers a new sweep.
//   Reset asserted mid-sweep aborts immediately to the reset values; no partial result is retained.
//   A, B, BUSY, DONE, PASS and ERR_CNT are all registered outputs; F1..F3 are sampled only in CHECK.
// CONFIGURATION
//   COMPARATOR_BIST_FAILLOG_EN defined:
//   - Adds outputs FAIL_VLD(1), FAIL_A(WIDTH), FAIL_B(WIDTH) and FAIL_F(3) = {F1,F2,F3}.
//   - These capture the first failing vector of a sweep; later failures do not overwrite them.
//   - All are cleared to 0 on reset and on START.
//   COMPARATOR_BIST_FAILLOG_EN undefined: these ports and registers do not exist; all other behaviour is identical.
// TESTING (WIDTH=1, SETTLE=2, CNT_W=8)
//   1. Ideal comparator model, START pulse -> A,B sweep 00,01,10,11; DONE=1 12 cycles after START;
//      PASS=1, ERR_CNT=0.
//   2. F1 stuck at 0 -> only vector A=1,B=0 fails; ERR_CNT=1, PASS=0; with FAILLOG_EN:
//      FAIL_A=1, FAIL_B=0, FAIL_F=3'b000.
//   3. F1 and F3 swapped -> vectors 01 and 10 fail; ERR_CNT=2; FAIL_A=0, FAIL_B=1, FAIL_F=3'b100.
//   4. START re-pulsed at cycle 5 of a sweep -> ignored; DONE still rises at cycle 12; one sweep only.
//   5. RST_N low at cycle 7 -> all outputs 0 asynchronously; new START gives a full, correct 12-cycle sweep.
//   6. WIDTH=2, CNT_W=2, all flags stuck at 0 -> 16 vectors fail; ERR_CNT saturates at 3;
//      DONE after 48 cycles.

Source files
------------

// File: rtl/comparator_bist.sv
// Self-test sequencer: sweeps every {A,B} pair into a magnitude comparator and counts flag mismatches.
// Optional first-failure log enabled by defining COMPARATOR_BIST_FAILLOG_EN.
module comparator_bist #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic             f1_i,
  input  logic             f2_i,
  input  logic             f3_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o
`ifdef COMPARATOR_BIST_FAILLOG_EN
  ,
  output logic             fail_vld_o,
  output logic [WIDTH-1:0] fail_a_o,
  output logic [WIDTH-1:0] fail_b_o,
  output logic [2:0]       fail_f_o
`endif
);

  localparam int VW       = 2 * WIDTH;
  localparam int CNT_BITS = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_BITS-1:0] RELOAD = CNT_BITS'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [VW-1:0]       vec_q, vec_d;
  logic [CNT_BITS-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [WIDTH-1:0]    op_a, op_b;
  logic [2:0]          exp_flags, got_flags;
  logic                mismatch;
`ifdef COMPARATOR_BIST_FAILLOG_EN
  logic                fvld_q, fvld_d;
  logic [WIDTH-1:0]    fa_q, fa_d, fb_q, fb_d;
  logic [2:0]          ff_q, ff_d;
`endif

  assign op_a      = vec_q[VW-1:WIDTH];
  assign op_b      = vec_q[WIDTH-1:0];
  assign exp_flags = {op_a > op_b, op_a == op_b, op_a < op_b};
  assign got_flags = {f1_i, f2_i, f3_i};
  assign mismatch  = (exp_flags != got_flags);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef COMPARATOR_BIST_FAILLOG_EN
    fvld_d  = fvld_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    ff_d    = ff_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          wait_d  = RELOAD;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef COMPARATOR_BIST_FAILLOG_EN
          fvld_d  = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
          ff_d    = '0;
`endif
        end
      end
      S_SETTLE: begin
        if (wait_q == '0) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - CNT_BITS'(1);
        end
      end
      S_CHECK: begin
        // Count saturates so a badly broken comparator cannot wrap back to a clean result.
        if (mismatch && (err_q != {CNT_W{1'b1}})) begin
          err_d = err_q + CNT_W'(1);
        end
`ifdef COMPARATOR_BIST_FAILLOG_EN
        if (mismatch && !fvld_q) begin
          fvld_d = 1'b1;
          fa_d   = op_a;
          fb_d   = op_b;
          ff_d   = got_flags;
        end
`endif
        if (vec_q == {VW{1'b1}}) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + VW'(1);
          wait_d  = RELOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef COMPARATOR_BIST_FAILLOG_EN
      fvld_q  <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      ff_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef COMPARATOR_BIST_FAILLOG_EN
      fvld_q  <= fvld_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      ff_q    <= ff_d;
`endif
    end
  end

  assign a_o       = op_a;
  assign b_o       = op_b;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_q;
`ifdef COMPARATOR_BIST_FAILLOG_EN
  assign fail_vld_o = fvld_q;
  assign fail_a_o   = fa_q;
  assign fail_b_o   = fb_q;
  assign fail_f_o   = ff_q;
`endif

endmodule

// File: tb/tb_comparator_bist.sv
// Scoreboard bench for comparator_bist: two instances (1-bit/8-bit count and 2-bit/2-bit count)
// driven by a faulty-comparator model whose expected sweep result is computed per START.
module tb_comparator_bist;

  localparam int S = 2;

  typedef logic [2:0] mask_t [16];
  typedef struct {
    int         startEdge;
    int         errCnt;
    bit         pass;
    bit         failVld;
    int         failA;
    int         failB;
    logic [2:0] failF;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start2;
  logic [0:0] a1, b1;
  logic [1:0] a2, b2;
  logic       f1a, f2a, f3a, f1b, f2b, f3b;
  logic       busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0] err1;
  logic [1:0] err2;
  logic [3:0] idx1, idx2;
`ifdef COMPARATOR_BIST_FAILLOG_EN
  logic       fv1, fv2;
  logic [0:0] fa1, fb1;
  logic [1:0] fa2, fb2;
  logic [2:0] ff1, ff2;
`endif

  int    mode1 = 0, mode2 = 0;
  mask_t mask1, mask2;
  int    cycleCount = 0;
  int    checks = 0, errors = 0;
  exp_t  q1[$], q2[$];

  comparator_bist #(.WIDTH(1), .SETTLE(S), .CNT_W(8)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .a_o(a1), .b_o(b1),
    .f1_i(f1a), .f2_i(f2a), .f3_i(f3a), .busy_o(busy1), .done_o(done1),
    .pass_o(pass1), .err_cnt_o(err1)
`ifdef COMPARATOR_BIST_FAILLOG_EN
    , .fail_vld_o(fv1), .fail_a_o(fa1), .fail_b_o(fb1), .fail_f_o(ff1)
`endif
  );

  comparator_bist #(.WIDTH(2), .SETTLE(S), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .a_o(a2), .b_o(b2),
    .f1_i(f1b), .f2_i(f2b), .f3_i(f3b), .busy_o(busy2), .done_o(done2),
    .pass_o(pass2), .err_cnt_o(err2)
`ifdef COMPARATOR_BIST_FAILLOG_EN
    , .fail_vld_o(fv2), .fail_a_o(fa2), .fail_b_o(fb2), .fail_f_o(ff2)
`endif
  );

  function automatic logic [2:0] idealFlags(input int a, input int b);
    return {a > b, a == b, a < b};
  endfunction

  // Fault modes: 0 ideal, 1 F1 stuck low, 2 F1/F3 swapped, 3 all stuck low, 4 random XOR per vector.
  function automatic logic [2:0] faultyFlags(input int mode, input int a, input int b, input logic [2:0] m);
    logic [2:0] g;
    g = idealFlags(a, b);
    case (mode)
      0:       return g;
      1:       return {1'b0, g[1:0]};
      2:       return {g[0], g[1], g[2]};
      3:       return 3'b000;
      default: return g ^ m;
    endcase
  endfunction

  assign idx1 = {2'b00, a1, b1};
  assign idx2 = {a2, b2};
  always_comb {f1a, f2a, f3a} = faultyFlags(mode1, int'(a1), int'(b1), mask1[idx1]);
  always_comb {f1b, f2b, f3b} = faultyFlags(mode2, int'(a2), int'(b2), mask2[idx2]);

  function automatic exp_t refModel(input int mode, input int w, input int cntMax,
                                    input int startEdge, input mask_t m);
    exp_t       e;
    logic [2:0] got;
    int         a, b;
    e.startEdge = startEdge;
    e.errCnt    = 0;
    e.failVld   = 0;
    e.failA     = 0;
    e.failB     = 0;
    e.failF     = 3'b000;
    for (int v = 0; v < (1 << (2 * w)); v++) begin
      a   = v >> w;
      b   = v & ((1 << w) - 1);
      got = faultyFlags(mode, a, b, m[v]);
      if (got != idealFlags(a, b)) begin
        if (e.errCnt < cntMax) e.errCnt++;
        if (!e.failVld) begin
          e.failVld = 1;
          e.failA   = a;
          e.failB   = b;
          e.failF   = got;
        end
      end
    end
    e.pass = (e.errCnt == 0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cycleCount);
    end
  endtask

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Monitor for instance 1: vector order while busy, then the full result when DONE rises.
  logic prevDone1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy1 && q1.size() > 0)
      checkOutput("vector1", int'({a1, b1}), (cycleCount - q1[0].startEdge) / (S + 1));
    if (done1 && !prevDone1) begin
      if (q1.size() == 0) begin
        checkOutput("unexpectedDone1", 1, 0);
      end else begin
        e = q1.pop_front();
        checkOutput("doneLatency1", cycleCount, e.startEdge + 4 * (S + 1));
        checkOutput("errCnt1", int'(err1), e.errCnt);
        checkOutput("pass1", int'(pass1), int'(e.pass));
        checkOutput("busyAtDone1", int'(busy1), 0);
        checkOutput("lastVector1", int'({a1, b1}), 3);
`ifdef COMPARATOR_BIST_FAILLOG_EN
        checkOutput("failVld1", int'(fv1), int'(e.failVld));
        checkOutput("failA1", int'(fa1), e.failA);
        checkOutput("failB1", int'(fb1), e.failB);
        checkOutput("failF1", int'(ff1), int'(e.failF));
`endif
      end
    end
    prevDone1 <= done1;
  end

  logic prevDone2 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done2 && !prevDone2) begin
      if (q2.size() == 0) begin
        checkOutput("unexpectedDone2", 1, 0);
      end else begin
        e = q2.pop_front();
        checkOutput("doneLatency2", cycleCount, e.startEdge + 16 * (S + 1));
        checkOutput("errCnt2", int'(err2), e.errCnt);
        checkOutput("pass2", int'(pass2), int'(e.pass));
        checkOutput("lastVector2", int'({a2, b2}), 15);
`ifdef COMPARATOR_BIST_FAILLOG_EN
        checkOutput("failVld2", int'(fv2), int'(e.failVld));
        checkOutput("failA2", int'(fa2), e.failA);
        checkOutput("failB2", int'(fb2), e.failB);
        checkOutput("failF2", int'(ff2), int'(e.failF));
`endif
      end
    end
    prevDone2 <= done2;
  end

  task automatic applyStimulus(input int mode);
    @(negedge clk);
    mode1 = mode;
    for (int i = 0; i < 16; i++) mask1[i] = 3'($urandom_range(0, 7));
    q1.push_back(refModel(mode, 1, 255, cycleCount + 1, mask1));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic applyStimulus2(input int mode);
    @(negedge clk);
    mode2 = mode;
    for (int i = 0; i < 16; i++) mask2[i] = 3'($urandom_range(0, 7));
    q2.push_back(refModel(mode, 2, 3, cycleCount + 1, mask2));
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic waitDone(input int which, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 1 && done1) || (which == 2 && done2)) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic checkAllZero1(input string tag);
    checkOutput({tag, "_ab"}, int'({a1, b1}), 0);
    checkOutput({tag, "_busy"}, int'(busy1), 0);
    checkOutput({tag, "_done"}, int'(done1), 0);
    checkOutput({tag, "_pass"}, int'(pass1), 0);
    checkOutput({tag, "_err"}, int'(err1), 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mask1[i] = 3'b000;
      mask2[i] = 3'b000;
    end
    repeat (2) @(negedge clk);
    checkAllZero1("reset");
    checkOutput("reset_busy2", int'(busy2), 0);
    rst_n = 1'b1;

    applyStimulus(0);
    waitDone(1, 100);
    applyStimulus(1);
    waitDone(1, 100);
    applyStimulus(2);
    waitDone(1, 100);

    // A second START mid-sweep must not restart the sequence.
    applyStimulus(0);
    repeat (3) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    waitDone(1, 100);

    applyStimulus(1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero1("abort");
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0);
    waitDone(1, 100);

    // START held through a whole sweep: ignored while busy, retriggers once DONE.
    @(negedge clk);
    mode1 = 1;
    q1.push_back(refModel(1, 1, 255, cycleCount + 1, mask1));
    start1 = 1'b1;
    waitDone(1, 100);
    q1.push_back(refModel(1, 1, 255, cycleCount + 1, mask1));
    @(negedge clk);
    start1 = 1'b0;
    waitDone(1, 100);

    repeat (6) begin
      applyStimulus($urandom_range(0, 4));
      waitDone(1, 100);
    end

    applyStimulus2(3);
    waitDone(2, 200);
    applyStimulus2(0);
    waitDone(2, 200);
    repeat (3) begin
      applyStimulus2($urandom_range(0, 4));
      waitDone(2, 200);
    end

    repeat (3) @(negedge clk);
    checkOutput("pendingSb1", q1.size(), 0);
    checkOutput("pendingSb2", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
